// File: rtl/wb_stage_pipe.sv
// Registered write-back stage: MEM/WB pipeline register, load alignment and extension,
// result selection and register-file write port, with variable-latency load data.
module wb_stage_pipe #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned LINK_OFFSET = 8,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_regwrite,
  input  logic              mem_memtoreg,
  input  logic              mem_link,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [2:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_alu,
  input  logic [DATA_W-1:0] mem_pc,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_rvalid,
  input  logic              flush,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_err,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);

  localparam logic [1:0] StEmpty    = 2'd0;
  localparam logic [1:0] StLoadWait = 2'd1;
  localparam logic [1:0] StReady    = 2'd2;

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // At DATA_W=32 the byte offset only spans one 4-byte word.
  localparam logic [2:0] OffMask = (DATA_W == 32) ? 3'b011 : 3'b111;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q;
  logic              rdata_we;

  logic              regwrite_q;
  logic              memtoreg_q;
  logic              link_q;
  logic [REG_AW-1:0] rd_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [2:0]        off_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] pc_q;

  logic accept;
  logic in_load;

  assign mem_ready = (state_q != StLoadWait);
  assign accept    = mem_valid & mem_ready & ~flush;
  assign in_load   = mem_memtoreg & ~mem_link;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    rdata_we = 1'b0;
    if (flush) begin
      state_d = StEmpty;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StLoadWait: begin
          if (dmem_rvalid) begin
            rdata_we = 1'b1;
            cnt_d    = '0;
            state_d  = StReady;
          end else begin
            cnt_d = cnt_q + CntW'(1);
            if ((TIMEOUT != 0) && (cnt_d == CntW'(TIMEOUT))) begin
              state_d = StEmpty;
              cnt_d   = '0;
              err_d   = 1'b1;
            end
          end
        end
        default: begin
          if (accept) begin
            cnt_d = '0;
            if (in_load && !dmem_rvalid) begin
              state_d = StLoadWait;
            end else begin
              state_d  = StReady;
              rdata_we = in_load;
            end
          end else begin
            state_d = StEmpty;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StEmpty;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      link_q     <= 1'b0;
      rd_q       <= '0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      off_q      <= 3'b000;
      alu_q      <= '0;
      pc_q       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (rdata_we) begin
        rdata_q <= dmem_rdata;
      end
      if (accept) begin
        regwrite_q <= mem_regwrite;
        memtoreg_q <= mem_memtoreg;
        link_q     <= mem_link;
        rd_q       <= mem_rd;
        size_q     <= mem_size;
        signed_q   <= mem_signed;
        off_q      <= mem_addr_lo;
        alu_q      <= mem_alu;
        pc_q       <= mem_pc;
      end
    end
  end

  // Load formatting: shift the addressed lane down to bit 0, then extend.
  logic [2:0]        off;
  logic [1:0]        size_eff;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_val;
  logic              misalign_raw;
  logic              sbit;

  always_comb begin
    off          = off_q & OffMask;
    size_eff     = ((DATA_W == 32) && (size_q == 2'b11)) ? 2'b10 : size_q;
    shifted      = rdata_q >> {off, 3'b000};
    load_val     = shifted;
    misalign_raw = 1'b0;
    sbit         = 1'b0;
    case (size_eff)
      2'b00: begin
        sbit           = signed_q & shifted[7];
        load_val       = {DATA_W{sbit}};
        load_val[7:0]  = shifted[7:0];
      end
      2'b01: begin
        sbit           = signed_q & shifted[15];
        load_val       = {DATA_W{sbit}};
        load_val[15:0] = shifted[15:0];
        misalign_raw   = off[0];
      end
      2'b10: begin
        sbit           = signed_q & shifted[31];
        load_val       = {DATA_W{sbit}};
        load_val[31:0] = shifted[31:0];
        misalign_raw   = (off[1:0] != 2'b00);
      end
      default: begin
        load_val     = shifted;
        misalign_raw = (off != 3'b000);
      end
    endcase
  end

  logic              in_ready;
  logic              misalign;
  logic [DATA_W-1:0] result;

  always_comb begin
    in_ready = (state_q == StReady);
    misalign = memtoreg_q & ~link_q & misalign_raw;
    if (link_q) begin
      result = pc_q + DATA_W'(LINK_OFFSET);
    end else if (memtoreg_q) begin
      result = load_val;
    end else begin
      result = alu_q;
    end
  end

  assign wb_we     = in_ready & regwrite_q & (rd_q != '0) & ~misalign;
  assign wb_waddr  = rd_q;
  assign wb_wdata  = result;
  assign wb_err    = err_q | (in_ready & misalign);
  assign fwd_valid = wb_we;
  assign fwd_rd    = wb_waddr;
  assign fwd_data  = wb_wdata;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench for wb_stage_pipe: a 32-bit and a 64-bit instance, each with a
// write scoreboard filled at issue time and drained by a negedge monitor.
module tb_wb_stage_pipe;

  logic        clk;
  logic        reset;
  logic        mem_regwrite, mem_memtoreg, mem_link, mem_signed, dmem_rvalid, flush;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_size;
  logic [2:0]  mem_addr_lo;

  logic        mem_valid, mem_ready, wb_we, wb_err, fwd_valid;
  logic [4:0]  wb_waddr, fwd_rd;
  logic [31:0] mem_alu, mem_pc, dmem_rdata, wb_wdata, fwd_data;

  logic        valid64, ready64, we64, err64, fv64;
  logic [4:0]  waddr64, frd64;
  logic [63:0] alu64, pc64, rdata64, wdata64, fd64;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [4:0] rd; logic [31:0] data;} exp32_t;
  typedef struct {logic [4:0] rd; logic [63:0] data;} exp64_t;
  exp32_t q32[$];
  exp64_t q64[$];
  exp32_t e32;
  exp64_t e64;

  wb_stage_pipe #(.DATA_W(32), .REG_AW(5), .LINK_OFFSET(8), .TIMEOUT(15)) dut32 (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_link(mem_link),
    .mem_rd(mem_rd), .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_addr_lo(mem_addr_lo), .mem_alu(mem_alu), .mem_pc(mem_pc),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .flush(flush),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_err(wb_err),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  wb_stage_pipe #(.DATA_W(64), .REG_AW(5), .LINK_OFFSET(8), .TIMEOUT(15)) dut64 (
    .clk(clk), .reset(reset), .mem_valid(valid64), .mem_ready(ready64),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_link(mem_link),
    .mem_rd(mem_rd), .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_addr_lo(mem_addr_lo), .mem_alu(alu64), .mem_pc(pc64),
    .dmem_rdata(rdata64), .dmem_rvalid(dmem_rvalid), .flush(flush),
    .wb_we(we64), .wb_waddr(waddr64), .wb_wdata(wdata64), .wb_err(err64),
    .fwd_valid(fv64), .fwd_rd(frd64), .fwd_data(fd64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wb_we === 1'b1) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL wr32_unexpected: got rd=%0d data=%h, required no write",
                 wb_waddr, wb_wdata);
      end else begin
        e32 = q32.pop_front();
        if ({wb_waddr, wb_wdata} !== {e32.rd, e32.data}) begin
          errors++;
          $display("FAIL wr32_data: got rd=%0d data=%h, required rd=%0d data=%h",
                   wb_waddr, wb_wdata, e32.rd, e32.data);
        end
        checks++;
        if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, e32.rd, e32.data}) begin
          errors++;
          $display("FAIL fwd32: got v=%b rd=%0d data=%h, required v=1 rd=%0d data=%h",
                   fwd_valid, fwd_rd, fwd_data, e32.rd, e32.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (we64 === 1'b1) begin
      checks++;
      if (q64.size() == 0) begin
        errors++;
        $display("FAIL wr64_unexpected: got rd=%0d data=%h, required no write",
                 waddr64, wdata64);
      end else begin
        e64 = q64.pop_front();
        if ({waddr64, wdata64, fv64, frd64, fd64} !==
            {e64.rd, e64.data, 1'b1, e64.rd, e64.data}) begin
          errors++;
          $display("FAIL wr64_data: got rd=%0d data=%h fwd=%h, required rd=%0d data=%h",
                   waddr64, wdata64, fd64, e64.rd, e64.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rw, input logic mt, input logic lk, input logic [4:0] rd,
                        input logic [1:0] sz, input logic sg, input logic [2:0] off);
    mem_regwrite = rw;
    mem_memtoreg = mt;
    mem_link     = lk;
    mem_rd       = rd;
    mem_size     = sz;
    mem_signed   = sg;
    mem_addr_lo  = off;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({mem_ready, wb_we, wb_waddr, wb_wdata, wb_err, fwd_valid} !== {1'b1, 1'b0, 5'd0,
        32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset32: got rdy=%b we=%b a=%0d d=%h err=%b, required 1 0 0 0 0",
               mem_ready, wb_we, wb_waddr, wb_wdata, wb_err);
    end
    checks++;
    if ({ready64, we64, waddr64, wdata64, err64} !== {1'b1, 1'b0, 5'd0, 64'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset64: got rdy=%b we=%b d=%h err=%b, required 1 0 0 0",
               ready64, we64, wdata64, err64);
    end
    reset = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b0 || mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle: got we=%b rdy=%b, required we=0 rdy=1", wb_we, mem_ready);
    end
    tick();
  endtask

  task automatic test_alu();
    set_op(1'b1, 1'b0, 1'b0, 5'd3, 2'b10, 1'b0, 3'd0);
    mem_alu = 32'h1234_5678;
    q32.push_back('{5'd3, 32'h1234_5678});
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b1) begin
      errors++;
      $display("FAIL alu_latency: got we=%b, required 1", wb_we);
    end
    tick();
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b0) begin
      errors++;
      $display("FAIL alu_drain: got we=%b, required 0", wb_we);
    end
    tick();
  endtask

  task automatic test_load_late(input logic sg, input logic [31:0] exp);
    set_op(1'b1, 1'b1, 1'b0, 5'd4, 2'b00, sg, 3'd2);
    dmem_rvalid = 1'b0;
    q32.push_back('{5'd4, exp});
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_ready !== 1'b0 || wb_we !== 1'b0) begin
        errors++;
        $display("FAIL load_wait[%0d]: got rdy=%b we=%b, required 0 0", i, mem_ready, wb_we);
      end
      if (i == 2) begin
        dmem_rdata  = 32'h0080_0000;
        dmem_rvalid = 1'b1;
      end
      tick();
    end
    dmem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b1 || mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_commit: got we=%b rdy=%b, required 1 1", wb_we, mem_ready);
    end
    tick();
  endtask

  task automatic test_link();
    set_op(1'b1, 1'b0, 1'b1, 5'd1, 2'b10, 1'b0, 3'd0);
    mem_pc = 32'h0040_0010;
    q32.push_back('{5'd1, 32'h0040_0018});
    mem_valid = 1'b1;
    tick();
    // Link wins over memtoreg and must not wait for load data.
    set_op(1'b1, 1'b1, 1'b1, 5'd2, 2'b10, 1'b0, 3'd0);
    dmem_rvalid = 1'b0;
    q32.push_back('{5'd2, 32'h0040_0018});
    tick();
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b1 || mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL link_mem: got we=%b rdy=%b, required 1 1", wb_we, mem_ready);
    end
    tick();
  endtask

  task automatic test_misalign();
    set_op(1'b1, 1'b1, 1'b0, 5'd5, 2'b01, 1'b1, 3'd1);
    dmem_rdata  = 32'h1234_5678;
    dmem_rvalid = 1'b1;
    mem_valid   = 1'b1;
    tick();
    mem_valid   = 1'b0;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b0 || wb_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign: got we=%b err=%b, required we=0 err=1", wb_we, wb_err);
    end
    tick();
    @(negedge clk);
    checks++;
    if (wb_err !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse: got err=%b, required 0", wb_err);
    end
    tick();
  endtask

  task automatic test_timeout();
    set_op(1'b1, 1'b1, 1'b0, 5'd6, 2'b10, 1'b0, 3'd0);
    dmem_rvalid = 1'b0;
    mem_valid   = 1'b1;
    tick();
    mem_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (mem_ready !== 1'b0 || wb_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: got rdy=%b err=%b, required 0 0",
                 i, mem_ready, wb_err);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (wb_err !== 1'b1 || mem_ready !== 1'b1 || wb_we !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: got err=%b rdy=%b we=%b, required 1 1 0",
               wb_err, mem_ready, wb_we);
    end
    tick();
    @(negedge clk);
    checks++;
    if (wb_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got err=%b, required 0", wb_err);
    end
    tick();
  endtask

  task automatic test_flush();
    set_op(1'b1, 1'b1, 1'b0, 5'd14, 2'b10, 1'b0, 3'd0);
    dmem_rvalid = 1'b0;
    mem_valid   = 1'b1;
    tick();
    mem_valid = 1'b0;
    tick();
    flush       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h55;
    tick();
    flush       = 1'b0;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b1 || wb_we !== 1'b0 || wb_err !== 1'b0) begin
      errors++;
      $display("FAIL flush_wait: got rdy=%b we=%b err=%b, required 1 0 0",
               mem_ready, wb_we, wb_err);
    end
    tick();
    set_op(1'b1, 1'b0, 1'b0, 5'd9, 2'b10, 1'b0, 3'd0);
    mem_alu   = 32'h99;
    mem_valid = 1'b1;
    flush     = 1'b1;
    tick();
    mem_valid = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept: got we=%b, required 0", wb_we);
    end
    tick();
    // An instruction already in READY commits despite a flush that cycle.
    set_op(1'b1, 1'b0, 1'b0, 5'd10, 2'b10, 1'b0, 3'd0);
    mem_alu = 32'h10;
    q32.push_back('{5'd10, 32'h10});
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    flush     = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b1) begin
      errors++;
      $display("FAIL flush_commit: got we=%b, required 1", wb_we);
    end
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_op(1'b1, 1'b1, 1'b0, 5'd11, 2'b10, 1'b0, 3'd0);
    dmem_rvalid = 1'b0;
    mem_valid   = 1'b1;
    tick();
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0 || wb_waddr !== 5'd11) begin
      errors++;
      $display("FAIL pre_reset_wait: got rdy=%b a=%0d, required 0 11", mem_ready, wb_waddr);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({mem_ready, wb_we, wb_waddr, wb_wdata, wb_err} !== {1'b1, 1'b0, 5'd0, 32'd0,
        1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b we=%b a=%0d d=%h err=%b, required 1 0 0 0 0",
               mem_ready, wb_we, wb_waddr, wb_wdata, wb_err);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sz [5]  = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b00};
    logic        mt [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        sg [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  off [5] = '{3'd0, 3'd0, 3'd2, 3'd0, 3'd7};
    logic [4:0]  rd [5]  = '{5'd1, 5'd0, 5'd2, 5'd12, 5'd13};
    logic [31:0] alu [5] = '{32'hA5A5_0001, 32'hDEAD, 32'h0, 32'h0BAD_F00D, 32'h0};
    logic [31:0] rdt [5] = '{32'h0, 32'h0, 32'h8001_0000, 32'h0, 32'hC300_0000};
    logic        ewe [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] exd [5] = '{32'hA5A5_0001, 32'h0, 32'hFFFF_8001, 32'h0BAD_F00D, 32'hC3};
    for (int k = 0; k < 5; k++) begin
      set_op(1'b1, mt[k], 1'b0, rd[k], sz[k], sg[k], off[k]);
      mem_alu     = alu[k];
      dmem_rdata  = rdt[k];
      dmem_rvalid = 1'b1;
      mem_valid   = 1'b1;
      if (ewe[k]) q32.push_back('{rd[k], exd[k]});
      tick();
      @(negedge clk);
      checks++;
      if (wb_we !== ewe[k] || wb_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d]: got we=%b err=%b, required we=%b err=0",
                 k, wb_we, wb_err, ewe[k]);
      end
    end
    mem_valid   = 1'b0;
    dmem_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_dw64();
    logic [1:0]  sz [5]  = '{2'b11, 2'b10, 2'b10, 2'b00, 2'b11};
    logic        sg [5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  off [5] = '{3'd0, 3'd4, 3'd4, 3'd7, 3'd4};
    logic [4:0]  rd [5]  = '{5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
    logic [63:0] rdt [5] = '{64'h8000_0000_0000_0001, 64'h8765_4321_0000_0000,
                             64'h8765_4321_0000_0000, 64'hAB00_0000_0000_0000, 64'h1};
    logic        ewe [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        eer [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [63:0] exd [5] = '{64'h8000_0000_0000_0001, 64'hFFFF_FFFF_8765_4321,
                             64'h0000_0000_8765_4321, 64'hAB, 64'h0};
    for (int k = 0; k < 5; k++) begin
      set_op(1'b1, 1'b1, 1'b0, rd[k], sz[k], sg[k], off[k]);
      rdata64     = rdt[k];
      dmem_rvalid = 1'b1;
      valid64     = 1'b1;
      if (ewe[k]) q64.push_back('{rd[k], exd[k]});
      tick();
      @(negedge clk);
      checks++;
      if (we64 !== ewe[k] || err64 !== eer[k]) begin
        errors++;
        $display("FAIL dw64[%0d]: got we=%b err=%b, required we=%b err=%b",
                 k, we64, err64, ewe[k], eer[k]);
      end
    end
    valid64     = 1'b0;
    dmem_rvalid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (we64 !== 1'b0 || err64 !== 1'b0) begin
      errors++;
      $display("FAIL dw64_drain: got we=%b err=%b, required 0 0", we64, err64);
    end
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    mem_valid   = 1'b0;
    valid64     = 1'b0;
    flush       = 1'b0;
    dmem_rvalid = 1'b0;
    mem_alu     = '0;
    mem_pc      = '0;
    dmem_rdata  = '0;
    alu64       = '0;
    pc64        = '0;
    rdata64     = '0;
    set_op(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 3'd0);

    test_reset();
    test_alu();
    test_load_late(1'b1, 32'hFFFF_FF80);
    test_load_late(1'b0, 32'h0000_0080);
    test_link();
    test_misalign();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_dw64();

    checks++;
    if (q32.size() != 0 || q64.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending writes, required 0/0",
               q32.size(), q64.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
